mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates the single main-memory port between instruction-cache line refills and data-cache refills/evictions. The memory model behind the port has variable latency. Each transaction is sequenced through grant, memory wait and response phases. Fixed dcache priority with a starvation guard is the default; round-robin is available as a build option. Sits between icache/dcache miss logic and the mem block.

Parameters:
ADDR_W, 32, byte address width of all address ports
LINE_W, 128, cache line width (4 x 32-bit words)
STARVE_MAX, 3, consecutive dcache grants allowed while ic_req is pending before icache is forced

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ic_req  in  1  icache line-read request; held until ic_valid
ic_addr  in  ADDR_W  icache line address; stable while ic_req
ic_valid  out  1  one-cycle pulse; ic_rdata valid
ic_rdata  out  LINE_W  returned line
dc_req  in  1  dcache request; held until dc_valid
dc_we  in  1  1 = line write-back, 0 = line read
dc_addr  in  ADDR_W  dcache line address; stable while dc_req
dc_wdata  in  LINE_W  write-back line; stable while dc_req
dc_valid  out  1  one-cycle completion pulse
dc_rdata  out  LINE_W  returned line (reads); 0 on writes
mem_req  out  1  memory request; held until mem_done
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  LINE_W  memory write data
mem_done  in  1  one-cycle pulse; mem_rdata valid on reads
mem_rdata  in  LINE_W  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0; starvation counter 0; RR pointer favours icache. Any in-flight transaction is discarded, and affected requesters reissue.
- States: IDLE, MEM_I, MEM_D, RESP_I, RESP_D.
- IDLE: samples ic_req and dc_req. On a winner, the transaction is latched into registers at the edge: addr, we (0 for icache), wdata. Next state is MEM_I or MEM_D. mem_req, mem_we, mem_addr and mem_wdata are registered outputs and assert in the following cycle.
- MEM_x: mem_* held stable. On an edge with mem_done=1: mem_rdata is captured into the x_rdata register (dc_rdata forced to 0 if the write bit is set), mem_req drops, and the block moves to RESP_x.
- RESP_x: x_valid=1 for exactly this cycle, then IDLE. x_rdata holds its value until the next response to that requester.
- Requester rule: req is deasserted at the edge that samples x_valid=1. The arbiter therefore always spends at least one IDLE cycle between transactions. No back-to-back grants.
- Latency: req seen in IDLE at cycle 0 -> mem_req at cycle 1. mem_done at cycle 1+k -> x_valid at cycle 2+k.
- Fixed priority (default): dcache wins ties.
  - Starvation counter increments on each dcache grant made while ic_req=1, and clears on any icache grant.
  - When the counter reaches STARVE_MAX, icache wins the next tie.
  - The counter saturates and does not wrap.
- mem_done in IDLE or RESP_x is ignored.
- A request dropped mid-transaction is a protocol violation. The transaction still completes and still produces x_valid.
- A 1-cycle request pulse is legal only if sampled in IDLE.

Optional Feature:
MEM_ARB_RR_EN: when defined, ties go to the requester not granted most recently. The pointer updates on each grant, the starvation counter and STARVE_MAX are unused, and the policy is otherwise identical. When undefined, fixed dcache priority with the starvation guard applies.

Test Plan:
1. Reset, no requests, 20 cycles -> all outputs 0, busy=0; a mem_done pulse is ignored.
2. ic_req with ic_addr=0x2000, memory done k=3 cycles after mem_req, rdata=0xDEADBEEF_01234567_89ABCDEF_0F0F0F0F -> mem_req at cycle 1 with mem_addr=0x2000 and mem_we=0; ic_valid single pulse at cycle 5 with matching data; dc_valid stays 0.
3. ic_req and dc_req (read, 0x3000) raised in the same cycle, fixed mode -> mem_addr sequence 0x3000 then 0x2000; dc_valid precedes ic_valid; at least 1 IDLE cycle between grants.
4. STARVE_MAX=2, dc_req reissued immediately after each completion, ic_req held -> grant order D, D, I, D, D, I. Under MEM_ARB_RR_EN -> D, I, D, I.
5. dc write: dc_we=1, dc_addr=0x4010, dc_wdata=0x...AA -> mem_we=1, mem_wdata=0x...AA; dc_valid pulses with dc_rdata=0.
6. Reset asserted in MEM_I before mem_done -> outputs 0 immediately (asynchronous); a later mem_done is ignored and no ic_valid appears. After ic_req is reissued, the transaction completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter between icache refills and dcache refills/write-backs.
// Default policy is fixed dcache priority with a starvation guard; define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 128,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_valid,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_valid,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, MEM_I, MEM_D, RESP_I, RESP_D} state_t;

    state_t state, state_nxt;
    logic   grant_ic, grant_dc;
    logic   favour_ic;
    logic   done_i, done_d;

`ifdef MEM_ARB_RR_EN
    logic rr_ic;

    assign favour_ic = rr_ic;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         rr_ic <= 1'b1;
        else if (grant_ic) rr_ic <= 1'b0;
        else if (grant_dc) rr_ic <= 1'b1;
    end
`else
    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    assign favour_ic = (starve_cnt >= CNT_MAX);

    // Only dcache wins that actually bypassed a waiting icache count toward starvation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (grant_ic)
            starve_cnt <= '0;
        else if (grant_dc && ic_req && starve_cnt < CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
    end
`endif

    assign done_i = (state == MEM_I) && mem_done;
    assign done_d = (state == MEM_D) && mem_done;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_ic  = 1'b0;
        grant_dc  = 1'b0;
        case (state)
            IDLE: begin
                if (ic_req && (!dc_req || favour_ic)) begin
                    grant_ic  = 1'b1;
                    state_nxt = MEM_I;
                end else if (dc_req) begin
                    grant_dc  = 1'b1;
                    state_nxt = MEM_D;
                end
            end
            MEM_I:   if (mem_done) state_nxt = RESP_I;
            MEM_D:   if (mem_done) state_nxt = RESP_D;
            RESP_I:  state_nxt = IDLE;
            RESP_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The mem_* registers double as the latched transaction; they hold until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_valid  <= 1'b0;
            dc_valid  <= 1'b0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
        end else begin
            ic_valid <= done_i;
            dc_valid <= done_d;
            if (grant_ic) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= ic_addr;
                mem_wdata <= '0;
            end else if (grant_dc) begin
                mem_req   <= 1'b1;
                mem_we    <= dc_we;
                mem_addr  <= dc_addr;
                mem_wdata <= dc_wdata;
            end else if (done_i || done_d) begin
                mem_req <= 1'b0;
            end
            if (done_i) ic_rdata <= mem_rdata;
            if (done_d) dc_rdata <= mem_we ? '0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single refills, tie-breaking, starvation/round-robin order,
// write-back and asynchronous reset mid-transaction.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_valid;
    logic [LINE_W-1:0] ic_rdata;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_valid;
    logic [LINE_W-1:0] dc_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_done;
    logic [LINE_W-1:0] mem_rdata;
    logic              busy;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_MAX(2)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_valid(dc_valid), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t_req, t_vld, t0;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serves one memory transaction k cycles after mem_req and checks the grant and response.
    // drop = {ic, dc}: requests cleared at the edge that samples the valid pulse.
    task automatic run_txn(input string tag, input bit is_ic, input logic [ADDR_W-1:0] exp_addr,
                           input bit exp_we, input logic [LINE_W-1:0] exp_wdata, input int k,
                           input logic [LINE_W-1:0] rd, input bit [1:0] drop);
        int n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_grant"}, mem_req, 1'b1);
        if (mem_req !== 1'b1) return;
        t_req = cyc;
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_we"}, mem_we, exp_we);
        check({tag, "_wdata"}, mem_wdata, exp_wdata);
        repeat (k) @(posedge clk);
        #1 mem_done = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1 mem_done = 1'b0;
        @(negedge clk);
        t_vld = cyc;
        check({tag, "_ic_valid"}, ic_valid, is_ic);
        check({tag, "_dc_valid"}, dc_valid, !is_ic);
        check({tag, "_mem_req_drop"}, mem_req, 1'b0);
        if (is_ic) check({tag, "_ic_rdata"}, ic_rdata, rd);
        else       check({tag, "_dc_rdata"}, dc_rdata, exp_we ? '0 : rd);
        @(posedge clk);
        #1;
        if (drop[1]) ic_req = 1'b0;
        if (drop[0]) dc_req = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_end"}, {ic_valid, dc_valid, busy}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        string seq;
        reset = 1'b1;
        ic_req = 0; ic_addr = '0;
        dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
        mem_done = 0; mem_rdata = '0;

        // 1. reset and idle
        repeat (3) @(negedge clk);
        check("rst_ctrl", {mem_req, mem_we, ic_valid, dc_valid, busy}, 5'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0 || i == 19)
                check($sformatf("idle_%0d", i), {mem_req, mem_we, ic_valid, dc_valid, busy}, 5'b0);
        end
        check("idle_addr", mem_addr, '0);
        check("idle_wdata", mem_wdata, '0);
        check("idle_rdata", {ic_rdata, dc_rdata}, '0);
        @(posedge clk);
        #1 mem_done = 1'b1; mem_rdata = 128'hFFFF;
        @(posedge clk);
        #1 mem_done = 1'b0;
        @(negedge clk);
        check("idle_done_ignored", {mem_req, ic_valid, dc_valid, busy}, 4'b0);
        @(negedge clk);
        check("idle_done_ignored2", {ic_valid, dc_valid, busy, ic_rdata}, '0);

        // 2. single icache refill, k=3
        @(posedge clk);
        #1 ic_req = 1'b1; ic_addr = 32'h2000;
        t0 = cyc;
        run_txn("t2", 1'b1, 32'h2000, 1'b0, '0, 3,
                128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F, 2'b10);
        check("t2_req_lat", t_req - t0, 1);
        check("t2_vld_lat", t_vld - t0, 5);

        // 3. simultaneous requests: dcache first, then icache after an idle cycle
        @(posedge clk);
        #1 ic_req = 1'b1; ic_addr = 32'h2000;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h3000;
        run_txn("t3_d", 1'b0, 32'h3000, 1'b0, '0, 2, 128'h3333_0000_0000_0001, 2'b01);
        t0 = t_vld;
        run_txn("t3_i", 1'b1, 32'h2000, 1'b0, '0, 1, 128'h2222_0000_0000_0002, 2'b10);
        check("t3_order", t_vld > t0, 1'b1);

        // 4. both held: starvation guard (fixed) or alternation (round-robin)
`ifdef MEM_ARB_RR_EN
        seq = "DIDIDI";
`else
        seq = "DDIDDI";
`endif
        @(posedge clk);
        #1 ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (seq[i] == "I")
                run_txn($sformatf("t4_%0d", i), 1'b1, 32'h2000, 1'b0, '0, 1,
                        LINE_W'(i + 'h100), (i == 5) ? 2'b11 : 2'b00);
            else
                run_txn($sformatf("t4_%0d", i), 1'b0, 32'h3000, 1'b0, '0, 1,
                        LINE_W'(i + 'h200), (i == 5) ? 2'b11 : 2'b00);
        end

        // 5. dcache write-back: dc_rdata forced to 0, icache data retained
        @(posedge clk);
        #1 dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h4010;
        dc_wdata = 128'h5555_5555_5555_5555_5555_5555_5555_55AA;
        run_txn("t5", 1'b0, 32'h4010, 1'b1, 128'h5555_5555_5555_5555_5555_5555_5555_55AA, 2,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 2'b01);
        dc_we = 1'b0;
        check("t5_ic_rdata_held", ic_rdata, LINE_W'('h105));

        // 6. async reset while in MEM_I
        @(posedge clk);
        #1 ic_req = 1'b1; ic_addr = 32'h5000;
        @(negedge clk);
        @(negedge clk);
        check("t6_in_mem", {mem_req, busy}, 2'b11);
        #2 reset = 1'b1;
        #1;
        check("t6_async_ctrl", {mem_req, mem_we, ic_valid, dc_valid, busy}, 5'b0);
        check("t6_async_addr", mem_addr, '0);
        check("t6_async_rdata", ic_rdata, '0);
        ic_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 mem_done = 1'b1; mem_rdata = 128'hBAD;
        @(posedge clk);
        #1 mem_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t6_no_valid_%0d", i), {ic_valid, busy, mem_req}, 3'b000);
        end
        @(posedge clk);
        #1 ic_req = 1'b1;
        run_txn("t6_reissue", 1'b1, 32'h5000, 1'b0, '0, 2, 128'h5000_CAFE, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
